// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN sequencer and its datapath.
package snn_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CONV, POOL, FC, QUANT, OUT} state_t;

    localparam int IMG_W    = 6;
    localparam int FM_W     = IMG_W - 2;
    localparam int N_IMG    = 2;
    localparam int CONV_LAT = 2;
    localparam int IMG_PIX  = IMG_W * IMG_W;
    localparam int TOT_PIX  = N_IMG * IMG_PIX;
    localparam int CNT_W    = 7;
    localparam int CONV_DIV = 2295;
    localparam int FC_DIV   = 510;

endpackage

// File: rtl/snn_win_gen.sv
// Row-major conv window walker: issues (row,col) once its pixels are loaded,
// holding the current window while the datapath is not ready.
module snn_win_gen import snn_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             dp_ready,
    input  logic [CNT_W-1:0] base,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             conv_en,
    output logic [1:0]       row,
    output logic [1:0]       col
);

    logic             done;
    logic [CNT_W-1:0] need;

    // Bottom-right pixel of the window must already be in the buffer.
    assign need    = base + (CNT_W'(row) + CNT_W'(2)) * CNT_W'(IMG_W) + CNT_W'(col) + CNT_W'(2);
    assign conv_en = en & ~done & (load_cnt > need) & dp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            done <= 1'b0;
        end else if (restart) begin
            row  <= '0;
            col  <= '0;
            done <= 1'b0;
        end else if (conv_en) begin
            if (col == 2'(FM_W - 1)) begin
                col <= '0;
                if (row == 2'(FM_W - 1)) begin
                    row  <= '0;
                    done <= 1'b1;
                end else begin
                    row <= row + 2'd1;
                end
            end else begin
                col <= col + 2'd1;
            end
        end
    end

endmodule

// File: rtl/snn_sched.sv
// Sequencer for the two-image SNN datapath: input accounting, window issue,
// pool/FC/quant stepping. Optional clock-gate enables under SNN_CG_EN.
module snn_sched import snn_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       dp_ready,
    output logic       img_we,
    output logic       img_sel,
    output logic [5:0] img_addr,
    output logic       ker_we,
    output logic       wgt_we,
    output logic       conv_en,
    output logic       conv_sel,
    output logic [1:0] conv_row,
    output logic [1:0] conv_col,
    output logic       fm_we,
    output logic [1:0] fm_row,
    output logic [1:0] fm_col,
    output logic       fm_clr,
    output logic       pool_en,
    output logic [1:0] pool_idx,
    output logic       fc_en,
    output logic       quant_en,
    output logic       quant_slot,
    output logic       cg_img_en,
    output logic       cg_fm_en,
    output logic       cg_fc_en,
    output logic       out_valid,
    output logic       busy
);

    state_t           state;
    logic [CNT_W-1:0] load_cnt;
    logic             k;
    logic [3:0]       fm_cnt;

    logic [CONV_LAT:1]      vld_pipe;
    logic [CONV_LAT:1][1:0] row_pipe;
    logic [CONV_LAT:1][1:0] col_pipe;

    assign img_we   = in_valid & (load_cnt < CNT_W'(TOT_PIX));
    assign img_sel  = (load_cnt >= CNT_W'(IMG_PIX));
    assign img_addr = img_sel ? 6'(load_cnt - CNT_W'(IMG_PIX)) : 6'(load_cnt);
    assign ker_we   = img_we & (load_cnt < CNT_W'(9));
    assign wgt_we   = img_we & (load_cnt < CNT_W'(4));
    assign fm_clr   = (state == IDLE) & in_valid;
    assign conv_sel = k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                load_cnt <= '0;
        else if (state == OUT)  load_cnt <= '0;
        else if (img_we)        load_cnt <= load_cnt + CNT_W'(1);
    end

    snn_win_gen u_win (
        .clk      (clk),
        .rst      (rst),
        .en       (state == CONV),
        .restart  (state == QUANT),
        .dp_ready (dp_ready),
        .base     (k ? CNT_W'(IMG_PIX) : CNT_W'(0)),
        .load_cnt (load_cnt),
        .conv_en  (conv_en),
        .row      (conv_row),
        .col      (conv_col)
    );

    // Feature-map writes trail window issue by the fixed conv latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            row_pipe <= '0;
            col_pipe <= '0;
        end else begin
            vld_pipe[1] <= conv_en;
            row_pipe[1] <= conv_row;
            col_pipe[1] <= conv_col;
            for (int i = 2; i <= CONV_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
                col_pipe[i] <= col_pipe[i-1];
            end
        end
    end

    assign fm_we  = vld_pipe[CONV_LAT];
    assign fm_row = row_pipe[CONV_LAT];
    assign fm_col = col_pipe[CONV_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        fm_cnt <= '0;
        else if (fm_we) fm_cnt <= fm_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 1'b0;
            pool_en    <= 1'b0;
            pool_idx   <= '0;
            fc_en      <= 1'b0;
            quant_en   <= 1'b0;
            quant_slot <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pool_en    <= 1'b0;
            pool_idx   <= '0;
            fc_en      <= 1'b0;
            quant_en   <= 1'b0;
            quant_slot <= 1'b0;
            out_valid  <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                    k     <= 1'b0;
                end
                LOAD: state <= CONV;
                CONV: if (fm_we && fm_cnt == 4'd15) begin
                    state   <= POOL;
                    pool_en <= 1'b1;
                end
                POOL: if (pool_idx == 2'd3) begin
                    state <= FC;
                    fc_en <= 1'b1;
                end else begin
                    pool_en  <= 1'b1;
                    pool_idx <= pool_idx + 2'd1;
                end
                FC: begin
                    state      <= QUANT;
                    quant_en   <= 1'b1;
                    quant_slot <= k;
                end
                QUANT: if (k == 1'(N_IMG - 1)) begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end else begin
                    state <= CONV;
                    k     <= k + 1'b1;
                end
                OUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    k     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SNN_CG_EN
    // Enables change only while clk is low so the downstream gate never glitches.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cg_img_en <= 1'b0;
            cg_fm_en  <= 1'b0;
            cg_fc_en  <= 1'b0;
        end else begin
            cg_img_en <= img_we;
            cg_fm_en  <= fm_we | fm_clr;
            cg_fc_en  <= pool_en | fc_en | quant_en;
        end
    end
`else
    assign cg_img_en = 1'b1;
    assign cg_fm_en  = 1'b1;
    assign cg_fc_en  = 1'b1;
`endif

endmodule

// File: tb/tb_snn_sched.sv
// Bench for snn_sched: per-cycle compare against an event-schedule model.
module tb_snn_sched;

    localparam int MAXC  = 400;
    localparam int OV_B  = 4;
    localparam int CV_B  = 22;
    localparam int KER_B = 24;
    localparam int WGT_B = 23;
    localparam int PL_B  = 10;

    logic clk = 1'b0;
    logic rst, in_valid, dp_ready;
    logic img_we, img_sel, ker_we, wgt_we, conv_en, conv_sel, fm_we, fm_clr;
    logic pool_en, fc_en, quant_en, quant_slot, cg_img_en, cg_fm_en, cg_fc_en, out_valid, busy;
    logic [5:0] img_addr;
    logic [1:0] conv_row, conv_col, fm_row, fm_col, pool_idx;

    int total = 0;
    int bad   = 0;
    bit iv[MAXC];
    bit dr[MAXC];
    logic [32:0] obs[MAXC];
    logic [32:0] expv[MAXC];
    int exp_out;

`ifdef SNN_CG_EN
    localparam logic [32:0] RST_EXP = 33'd0;
`else
    localparam logic [32:0] RST_EXP = 33'd7;
`endif

    snn_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dp_ready(dp_ready),
        .img_we(img_we), .img_sel(img_sel), .img_addr(img_addr),
        .ker_we(ker_we), .wgt_we(wgt_we),
        .conv_en(conv_en), .conv_sel(conv_sel), .conv_row(conv_row), .conv_col(conv_col),
        .fm_we(fm_we), .fm_row(fm_row), .fm_col(fm_col), .fm_clr(fm_clr),
        .pool_en(pool_en), .pool_idx(pool_idx), .fc_en(fc_en),
        .quant_en(quant_en), .quant_slot(quant_slot),
        .cg_img_en(cg_img_en), .cg_fm_en(cg_fm_en), .cg_fc_en(cg_fc_en),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] pack_dut();
        return {img_we, img_we ? img_sel : 1'b0, img_we ? img_addr : 6'd0, ker_we, wgt_we,
                conv_en, conv_en ? {conv_sel, conv_row, conv_col} : 5'd0,
                fm_we, fm_we ? {fm_row, fm_col} : 4'd0, fm_clr,
                pool_en, pool_en ? pool_idx : 2'd0, fc_en,
                quant_en, quant_en ? quant_slot : 1'b0, out_valid, busy,
                cg_img_en, cg_fm_en, cg_fc_en};
    endfunction

    // Schedule derived from the rules: each window issues at the first cycle
    // after its predecessor where enough samples are in and dp_ready is high.
    task automatic build_model();
        int cntv[MAXC];
        bit we[MAXC], cv[MAXC], fw[MAXC], pl[MAXC], fcv[MAXC], qv[MAXC], ov[MAXC], by[MAXC], qs[MAXC];
        logic [4:0] cvw[MAXC];
        logic [3:0] fmw[MAXC];
        logic [1:0] pi[MAXC];
        int cnt, c0, prev, gate, t, fml, thr;
        logic [2:0] cg;
        cnt = 0; c0 = -1;
        for (int i = 0; i < MAXC; i++) begin
            we[i] = 0; cv[i] = 0; fw[i] = 0; pl[i] = 0; fcv[i] = 0; qv[i] = 0;
            ov[i] = 0; by[i] = 0; qs[i] = 0; cvw[i] = '0; fmw[i] = '0; pi[i] = '0;
        end
        for (int i = 0; i < MAXC; i++) begin
            cntv[i] = cnt;
            if (c0 < 0 && iv[i]) c0 = i;
            we[i] = (c0 >= 0) && iv[i] && (cnt < 72);
            if (we[i]) cnt++;
        end
        if (c0 < 0) c0 = 0;
        gate = c0 + 2; prev = -1;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) begin
                thr = k * 36 + (w / 4 + 2) * 6 + (w % 4) + 2;
                t = (prev + 1 > gate) ? prev + 1 : gate;
                while (t < MAXC - 10 && !(cntv[t] > thr && dr[t])) t++;
                cv[t] = 1; cvw[t] = {1'(k), 2'(w / 4), 2'(w % 4)};
                fw[t+2] = 1; fmw[t+2] = {2'(w / 4), 2'(w % 4)};
                prev = t;
            end
            fml = prev + 2;
            for (int i = 0; i < 4; i++) begin pl[fml+1+i] = 1; pi[fml+1+i] = 2'(i); end
            fcv[fml+5] = 1; qv[fml+6] = 1; qs[fml+6] = 1'(k);
            gate = fml + 7;
        end
        exp_out = gate;
        ov[exp_out] = 1;
        for (int i = c0 + 1; i <= exp_out; i++) by[i] = 1;
        for (int i = 0; i < MAXC; i++) begin
`ifdef SNN_CG_EN
            cg = {we[i], fw[i] | (i == c0), pl[i] | fcv[i] | qv[i]};
`else
            cg = 3'b111;
`endif
            expv[i] = {we[i], we[i] ? (cntv[i] >= 36) : 1'b0, we[i] ? 6'(cntv[i] % 36) : 6'd0,
                       we[i] && cntv[i] < 9, we[i] && cntv[i] < 4,
                       cv[i], cvw[i], fw[i], fmw[i], i == c0,
                       pl[i], pi[i], fcv[i], qv[i], qs[i], ov[i], by[i], cg};
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin iv[t] = 0; dr[t] = 1; end
    endtask

    task automatic drive_run(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            in_valid = iv[t]; dp_ready = dr[t];
            @(negedge clk); #1;
            obs[t] = pack_dut();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; dp_ready = 1'b0;
    endtask

    function automatic int first_at(input int bitpos, input int nth, input int n);
        int seen = 0;
        for (int t = 0; t < n; t++)
            if (obs[t][bitpos]) begin seen++; if (seen == nth) return t; end
        return -1;
    endfunction

    function automatic int count_of(input int bitpos, input int n);
        int c = 0;
        for (int t = 0; t < n; t++) if (obs[t][bitpos]) c++;
        return c;
    endfunction

    task automatic test_reset();
        logic [32:0] v;
        rst = 1'b1; in_valid = 1'b0; dp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        v = pack_dut();
        total++;
        if (v !== RST_EXP) begin bad++; $display("FAIL reset_state got %h want %h", v, RST_EXP); end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal();
        int n, v;
        clear_stim();
        for (int t = 0; t < 72; t++) iv[t] = 1;
        build_model();
        n = exp_out + 3;
        drive_run(n);
        for (int t = 0; t < n; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL nominal cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        v = first_at(OV_B, 1, n); total++;
        if (v !== 81) begin bad++; $display("FAIL nominal_out_cycle got %0d want 81", v); end
        v = first_at(CV_B, 1, n); total++;
        if (v !== 15) begin bad++; $display("FAIL nominal_first_conv got %0d want 15", v); end
        v = first_at(PL_B, 1, n); total++;
        if (v !== 39) begin bad++; $display("FAIL nominal_first_pool got %0d want 39", v); end
        v = first_at(CV_B, 17, n); total++;
        if (v !== 51) begin bad++; $display("FAIL nominal_img1_conv got %0d want 51", v); end
    endtask

    task automatic test_stall();
        int n, v;
        clear_stim();
        for (int t = 0; t < 72; t++) iv[t] = 1;
        for (int t = 16; t < 20; t++) dr[t] = 0;
        build_model();
        n = exp_out + 3;
        drive_run(n);
        for (int t = 0; t < n; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL stall cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        v = first_at(CV_B, 2, n); total++;
        if (v !== 20) begin bad++; $display("FAIL stall_win01 got %0d want 20", v); end
        v = count_of(OV_B, n); total++;
        if (v !== 1) begin bad++; $display("FAIL stall_out_pulses got %0d want 1", v); end
        v = count_of(CV_B, n); total++;
        if (v !== 32) begin bad++; $display("FAIL stall_windows got %0d want 32", v); end
    endtask

    task automatic test_gap();
        int n, v;
        clear_stim();
        for (int t = 0; t <= 72; t++) iv[t] = (t != 14);
        build_model();
        n = exp_out + 3;
        drive_run(n);
        for (int t = 0; t < n; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL gap cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        v = first_at(CV_B, 1, n); total++;
        if (v !== 16) begin bad++; $display("FAIL gap_first_conv got %0d want 16", v); end
        v = count_of(KER_B, n); total++;
        if (v !== 9) begin bad++; $display("FAIL gap_ker_we got %0d want 9", v); end
        v = count_of(WGT_B, n); total++;
        if (v !== 4) begin bad++; $display("FAIL gap_wgt_we got %0d want 4", v); end
    endtask

    task automatic test_extra();
        int n, v;
        clear_stim();
        for (int t = 0; t < 76; t++) iv[t] = 1;
        build_model();
        n = exp_out + 3;
        drive_run(n);
        for (int t = 0; t < n; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL extra cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        v = count_of(32, n); total++;
        if (v !== 72) begin bad++; $display("FAIL extra_img_we got %0d want 72", v); end
        v = first_at(OV_B, 1, n); total++;
        if (v !== 81) begin bad++; $display("FAIL extra_out_cycle got %0d want 81", v); end
    endtask

    task automatic test_reset_mid();
        int n, v;
        logic [32:0] o;
        clear_stim();
        for (int t = 0; t < 72; t++) iv[t] = 1;
        build_model();
        drive_run(40);
        for (int t = 0; t < 40; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL rstmid_pre cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        rst = 1'b1;
        @(negedge clk); #1;
        o = pack_dut(); total++;
        if (o !== RST_EXP) begin bad++; $display("FAIL rstmid_async got %h want %h", o, RST_EXP); end
        @(posedge clk); #1;
        o = pack_dut(); total++;
        if (o !== RST_EXP) begin bad++; $display("FAIL rstmid_edge got %h want %h", o, RST_EXP); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        n = exp_out + 3;
        drive_run(n);
        for (int t = 0; t < n; t++) begin
            total++;
            if (obs[t] !== expv[t]) begin bad++; $display("FAIL rstmid_rerun cyc %0d got %h want %h", t, obs[t], expv[t]); end
        end
        v = first_at(OV_B, 1, n); total++;
        if (v !== 81) begin bad++; $display("FAIL rstmid_out_cycle got %0d want 81", v); end
    endtask

    task automatic test_random();
        int n, acc;
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            acc = 0;
            for (int t = 0; t < MAXC; t++) begin
                if (acc < 72) begin
                    iv[t] = (t == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
                    if (iv[t]) acc++;
                end
                dr[t] = ($urandom_range(9, 0) < 7);
            end
            build_model();
            n = (exp_out + 3 < MAXC) ? exp_out + 3 : MAXC;
            drive_run(n);
            for (int t = 0; t < n; t++) begin
                total++;
                if (obs[t] !== expv[t]) begin bad++; $display("FAIL random%0d cyc %0d got %h want %h", it, t, obs[t], expv[t]); end
            end
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_gap();
        test_extra();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
